enable_clear_register: RTL and testbench
========================================

Name: enable_clear_register

Overview:
- Parameterised-width storage register with a synchronous load-enable and a synchronous clear.
- General-purpose holding element used wherever the datapath needs a cleared, gated pipeline or state register, e.g. accumulators, counters, captured operands.
- Single clock domain; asynchronous active-high reset.

Parameters:
- WIDTH, 8, data width in bits of d and q (must be ≥1).
- RST_VAL, 0 (WIDTH bits), value loaded into q on reset.
- CLR_VAL, 0 (WIDTH bits), value loaded into q on synchronous clear.

Ports:
- clk  input  1  rising-edge clock, sole clock of the block.
- rst  input  1  reset; asynchronous, active-high; forces q to RST_VAL.
- en  input  1  load enable; when high (and clr low), d is captured on the rising edge.
- clr  input  1  synchronous clear; when high, q takes CLR_VAL on the rising edge regardless of en.
- d  input  WIDTH  data to load.
- q  output  WIDTH  registered output.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: while rst=1, q=RST_VAL immediately, with no clock edge needed. Reset overrides clr, en and d.
- Reset release: q holds RST_VAL until the first rising edge with rst=0. The operation on that edge is decided by clr/en.
- Priority on each rising edge with rst=0:
  - 1) clr=1 → q ← CLR_VAL (en and d ignored).
  - 2) clr=0, en=1 → q ← d.
  - 3) clr=0, en=0 → q holds its value.
- Latency: one cycle. The d value present at rising edge N appears on q immediately after edge N.
- q is driven only by the flop, with no combinational path from d/en/clr to q.
- Simultaneous clr=1 and en=1: clear wins; q=CLR_VAL.
- Reset asserted mid-cycle or mid-operation: q goes to RST_VAL asynchronously. Any pending load or clear on a later edge during reset is discarded.
- clr held high for multiple cycles: q stays CLR_VAL.
- Width rules:
  - d is captured bit-exact.
  - No sign or zero extension inside the block.
  - RST_VAL and CLR_VAL are truncated to WIDTH bits if wider.
- X on en/clr while rst=0 is not required to be handled; the verification environment must keep the controls driven.

Test Plan:
- Reset: WIDTH=8, en=1, clr=0, d=0, rst=1 for one cycle → q=8'h00 while rst high; rst=0 → q stays 0 after the next edge (d=0).
- Load: en=1, clr=0, d=8 on one edge → q=8 after that edge; d=16 on the next edge → q=16.
- Clear priority: q=16, then clr=1, en=1, d=8'hAA → q=0 after the edge; hold clr=1 for another cycle → q stays 0.
- Hold: load q=8'h5A, then en=0, clr=0, d=8'hFF for 3 cycles → q remains 8'h5A.
- Async reset mid-cycle: q=8'h3C, assert rst between clock edges → q=0 before the next rising edge; release rst with en=1, d=8'h11 → q=8'h11 one edge later.
- Non-default parameters: WIDTH=16, RST_VAL=16'hBEEF, CLR_VAL=16'h1234:
  - reset → q=16'hBEEF;
  - load 16'h0F0F → q=16'h0F0F;
  - clr → q=16'h1234.

Source files
------------

// File: rtl/enable_clear_register.sv
// enable_clear_register
// Parameterised-width storage register with a synchronous load enable and a
// synchronous clear. Asynchronous active-high reset forces q to RST_VAL.
// Clear takes priority over load on every clock edge.
// q comes straight from the flop, so there is no combinational path from the inputs to q.

module enable_clear_register #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0,
    parameter logic [WIDTH-1:0]     CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage flop: reset wins asynchronously, then clear, then load, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_enable_clear_register.sv
// tb_enable_clear_register
// Directed bench for enable_clear_register: one default 8-bit instance and one
// 16-bit instance with non-zero reset and clear values. Expected values are
// pushed to a scoreboard queue when stimulus is driven and popped when q is sampled.

module tb_enable_clear_register;

    logic        clk;
    logic        rst8, en8, clr8;
    logic [7:0]  d8, q8;
    logic        rst16, en16, clr16;
    logic [15:0] d16, q16;

    logic [7:0]  model8;
    logic [15:0] model16;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    int checks;
    int errors;

    enable_clear_register #(
        .WIDTH(8)
    ) dut8 (
        .clk(clk),
        .rst(rst8),
        .en (en8),
        .clr(clr8),
        .d  (d8),
        .q  (q8)
    );

    enable_clear_register #(
        .WIDTH  (16),
        .RST_VAL(16'hBEEF),
        .CLR_VAL(16'h1234)
    ) dut16 (
        .clk(clk),
        .rst(rst16),
        .en (en16),
        .clr(clr16),
        .d  (d16),
        .q  (q16)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what q must be at the next sample point.
    task automatic pushExpect(input logic [15:0] value, input string tag);
        exp_q.push_back(value);
        tag_q.push_back(tag);
    endtask

    // Pop the oldest expectation and compare it against the sampled q.
    task automatic checkOutput(input logic [15:0] observed);
        logic [15:0] expected;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed %h expected <none>", observed);
        end else begin
            expected = exp_q.pop_front();
            tag      = tag_q.pop_front();
            assert (observed === expected)
            else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // One clock cycle on the 8-bit instance: drive on the falling edge, predict, sample after the rising edge.
    task automatic applyStimulus8(input logic e, input logic c, input logic [7:0] dv, input string tag);
        @(negedge clk);
        en8  = e;
        clr8 = c;
        d8   = dv;
        if (c)      model8 = 8'h00;
        else if (e) model8 = dv;
        pushExpect({8'h00, model8}, tag);
        @(posedge clk);
        #1;
        checkOutput({8'h00, q8});
    endtask

    // Same as above for the 16-bit instance (clear value 16'h1234).
    task automatic applyStimulus16(input logic e, input logic c, input logic [15:0] dv, input string tag);
        @(negedge clk);
        en16  = e;
        clr16 = c;
        d16   = dv;
        if (c)      model16 = 16'h1234;
        else if (e) model16 = dv;
        pushExpect(model16, tag);
        @(posedge clk);
        #1;
        checkOutput(q16);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst8  = 1'b0; en8  = 1'b1; clr8  = 1'b0; d8  = 8'h00;
        rst16 = 1'b0; en16 = 1'b0; clr16 = 1'b0; d16 = 16'h0000;
        model8  = 8'h00;
        model16 = 16'h0000;

        // Reset asserted between edges must take effect without a clock edge.
        #2;
        rst8  = 1'b1;
        rst16 = 1'b1;
        #1;
        model8  = 8'h00;
        model16 = 16'hBEEF;
        pushExpect({8'h00, model8}, "reset8_async");
        checkOutput({8'h00, q8});
        pushExpect(model16, "reset16_async");
        checkOutput(q16);

        // Reset held across a rising edge with en=1 still holds the reset value.
        @(negedge clk);
        d8  = 8'h77;
        d16 = 16'h7777;
        en16 = 1'b1;
        @(posedge clk);
        #1;
        pushExpect({8'h00, model8}, "reset8_held");
        checkOutput({8'h00, q8});
        pushExpect(model16, "reset16_held");
        checkOutput(q16);

        // Release reset on the falling edge; the next edge decides the operation.
        @(negedge clk);
        rst8  = 1'b0;
        rst16 = 1'b0;
        en16  = 1'b0;
        d8    = 8'h00;
        applyStimulus8(1'b1, 1'b0, 8'h00, "reset_release");

        // Basic loads with one-cycle latency.
        applyStimulus8(1'b1, 1'b0, 8'd8,  "load_8");
        applyStimulus8(1'b1, 1'b0, 8'd16, "load_16");

        // Clear beats enable, and stays cleared while held.
        applyStimulus8(1'b1, 1'b1, 8'hAA, "clear_priority");
        applyStimulus8(1'b1, 1'b1, 8'hAA, "clear_hold");

        // Hold with en=0 for three cycles.
        applyStimulus8(1'b1, 1'b0, 8'h5A, "load_5a");
        applyStimulus8(1'b0, 1'b0, 8'hFF, "hold_1");
        applyStimulus8(1'b0, 1'b0, 8'hFF, "hold_2");
        applyStimulus8(1'b0, 1'b0, 8'hFF, "hold_3");

        // Asynchronous reset in the middle of a cycle.
        applyStimulus8(1'b1, 1'b0, 8'h3C, "load_3c");
        @(negedge clk);
        en8  = 1'b1;
        d8   = 8'h99;
        #2;
        rst8 = 1'b1;
        #1;
        model8 = 8'h00;
        pushExpect({8'h00, model8}, "midcycle_reset");
        checkOutput({8'h00, q8});
        @(posedge clk);
        #1;
        pushExpect({8'h00, model8}, "load_during_reset");
        checkOutput({8'h00, q8});
        @(negedge clk);
        rst8 = 1'b0;
        applyStimulus8(1'b1, 1'b0, 8'h11, "after_reset_load");

        // A short burst of random control/data patterns.
        for (int i = 0; i < 12; i++) begin
            applyStimulus8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                           8'($urandom), "random8");
        end

        // Non-default parameters on the 16-bit instance.
        applyStimulus16(1'b0, 1'b0, 16'hFFFF, "w16_hold_reset_val");
        applyStimulus16(1'b1, 1'b0, 16'h0F0F, "w16_load");
        applyStimulus16(1'b0, 1'b1, 16'hAAAA, "w16_clear");
        applyStimulus16(1'b1, 1'b1, 16'h5555, "w16_clear_with_en");
        applyStimulus16(1'b1, 1'b0, 16'hC3A5, "w16_load_full");

        // Reset again after activity on the 16-bit instance.
        @(negedge clk);
        rst16 = 1'b1;
        #1;
        model16 = 16'hBEEF;
        pushExpect(model16, "w16_reset_again");
        checkOutput(q16);
        @(negedge clk);
        rst16 = 1'b0;

        if (exp_q.size() != 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
